// File: rtl/truth_table_checker_if.sv
// Bundle between the truth-table sweep engine and whatever drives/observes it.
// The master side owns start and the DUT response; the slave side is the checker.
interface truth_table_checker_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2
);
    logic             start;
    logic [N_IN-1:0]  vec_out;
    logic [N_OUT-1:0] resp_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_IN:0]    err_count;
    logic [N_IN-1:0]  first_err_vec;
    logic [N_OUT-1:0] first_err_resp;

    modport master (
        output start, resp_in,
        input  vec_out, busy, done, pass, err_count, first_err_vec, first_err_resp
    );

    modport slave (
        input  start, resp_in,
        output vec_out, busy, done, pass, err_count, first_err_vec, first_err_resp
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive on-chip sweep of a small combinational block: steps every input vector,
// lets it settle for HOLD cycles, and scores the response against EXP_TABLE.
module truth_table_checker #(
    parameter int                           N_IN      = 3,
    parameter int                           N_OUT     = 2,
    parameter int                           HOLD      = 4,
    parameter logic [N_OUT*(2**N_IN)-1:0]   EXP_TABLE = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_checker_if.slave bus
);

    localparam int              N_VEC    = 2**N_IN;
    localparam int              CW       = $clog2(HOLD);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);
    localparam logic [CW-1:0]   HOLD_MAX = CW'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, LAST, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    hold_cnt;
    logic [N_IN-1:0]  index;
    logic [N_OUT-1:0] expected;
    logic             mismatch;

    assign expected    = EXP_TABLE[int'(index)*N_OUT +: N_OUT];
    assign mismatch    = (bus.resp_in != expected);
    assign bus.vec_out = index;

    // resp_in only matters on the last cycle of each hold window; everything else is settle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            hold_cnt           <= '0;
            index              <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.pass           <= 1'b0;
            bus.err_count      <= '0;
            bus.first_err_vec  <= '0;
            bus.first_err_resp <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state              <= DRIVE;
                        hold_cnt           <= '0;
                        index              <= '0;
                        bus.busy           <= 1'b1;
                        bus.done           <= 1'b0;
                        bus.pass           <= 1'b0;
                        bus.err_count      <= '0;
                        bus.first_err_vec  <= '0;
                        bus.first_err_resp <= '0;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == HOLD_MAX) begin
                        hold_cnt <= '0;
                        if (mismatch) begin
                            bus.err_count <= bus.err_count + (N_IN+1)'(1);
                            if (bus.err_count == '0) begin
                                bus.first_err_vec  <= index;
                                bus.first_err_resp <= bus.resp_in;
                            end
                        end
                        if (index == LAST_IDX)
                            state <= LAST;
                        else
                            index <= index + N_IN'(1);
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                LAST: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    bus.pass <= (bus.err_count == '0);
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized bench for truth_table_checker: the responding logic is a lookup table
// the bench controls, scored against an F1/F2 reference computed arithmetically.
module tb_truth_table_checker;

    localparam int          N_IN      = 3;
    localparam int          N_OUT     = 2;
    localparam int          HOLD      = 2;
    localparam int          N_VEC     = 8;
    localparam int          SWEEP     = HOLD * N_VEC;
    localparam logic [15:0] EXP_TABLE = 16'hE99C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] resp_tbl [N_VEC];
    logic       glitch_en   = 1'b0;
    logic       sample_next = 1'b0;
    int         errors = 0;
    int         checks = 0;

    truth_table_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus();

    truth_table_checker #(
        .N_IN(N_IN), .N_OUT(N_OUT), .HOLD(HOLD), .EXP_TABLE(EXP_TABLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // During settle cycles the response can be made deliberately wrong; only the sample cycle is honest.
    always_comb begin
        if (glitch_en && !sample_next)
            bus.resp_in = ~resp_tbl[bus.vec_out];
        else
            bus.resp_in = resp_tbl[bus.vec_out];
    end

    function automatic logic [1:0] golden(input int v);
        logic x, y, z;
        x = v[2];
        y = v[1];
        z = v[0];
        return {(x & y) | z, x ^ y ^ z};
    endfunction

    task automatic set_golden();
        for (int v = 0; v < N_VEC; v++) resp_tbl[v] = golden(v);
    endtask

    task automatic model(output int n_err, output int f_vec, output int f_resp);
        n_err  = 0;
        f_vec  = 0;
        f_resp = 0;
        for (int v = 0; v < N_VEC; v++) begin
            if (resp_tbl[v] != golden(v)) begin
                if (n_err == 0) begin
                    f_vec  = v;
                    f_resp = int'(resp_tbl[v]);
                end
                n_err++;
            end
        end
    endtask

    // Pulses start, optionally pulses it again on edge extra_start, and follows the sweep edge by edge.
    task automatic run_sweep(input int extra_start);
        int exp_vec;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = (extra_start == 1);
        sample_next = ((1 % HOLD) == 0);
        checks += 3;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL start_busy: got %b expected 1", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL start_done_clear: got %b expected 0", bus.done); end
        if (bus.err_count !== 4'd0) begin errors++; $display("[TB] FAIL start_err_clear: got %0d expected 0", bus.err_count); end
        for (int e = 1; e <= SWEEP + 2; e++) begin
            @(posedge clk);
            #1;
            exp_vec = (e / HOLD > N_VEC - 1) ? N_VEC - 1 : e / HOLD;
            checks += 3;
            if (int'(bus.vec_out) != exp_vec) begin
                errors++;
                $display("[TB] FAIL vec_out edge %0d: got %0d expected %0d", e, bus.vec_out, exp_vec);
            end
            if (bus.done !== (e >= SWEEP + 1)) begin
                errors++;
                $display("[TB] FAIL done edge %0d: got %b expected %b", e, bus.done, e >= SWEEP + 1);
            end
            if (e != SWEEP + 1 && bus.busy !== (e < SWEEP + 1)) begin
                errors++;
                $display("[TB] FAIL busy edge %0d: got %b expected %b", e, bus.busy, e < SWEEP + 1);
            end
            bus.start   = (e + 1 == extra_start);
            sample_next = ((e + 1) % HOLD == 0) && (e + 1 <= SWEEP);
        end
        bus.start   = 1'b0;
        glitch_en   = 1'b0;
        sample_next = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_golden();
        #3;
        checks += 7;
        if (bus.vec_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_vec: got %0d expected 0", bus.vec_out); end
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        if (bus.pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass: got %b expected 0", bus.pass); end
        if (bus.err_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_err: got %0d expected 0", bus.err_count); end
        if (bus.first_err_vec !== 3'd0) begin errors++; $display("[TB] FAIL reset_fvec: got %0d expected 0", bus.first_err_vec); end
        if (bus.first_err_resp !== 2'd0) begin errors++; $display("[TB] FAIL reset_fresp: got %0d expected 0", bus.first_err_resp); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_sweep();
        set_golden();
        run_sweep(0);
        checks += 2;
        if (bus.pass !== 1'b1) begin errors++; $display("[TB] FAIL clean_pass: got %b expected 1", bus.pass); end
        if (bus.err_count !== 4'd0) begin errors++; $display("[TB] FAIL clean_err: got %0d expected 0", bus.err_count); end
    endtask

    task automatic test_corrupted_entries();
        set_golden();
        resp_tbl[3] = golden(3) ^ 2'b11;
        resp_tbl[5] = golden(5) ^ 2'b01;
        run_sweep(0);
        checks += 4;
        if (bus.pass !== 1'b0) begin errors++; $display("[TB] FAIL corrupt_pass: got %b expected 0", bus.pass); end
        if (bus.err_count !== 4'd2) begin errors++; $display("[TB] FAIL corrupt_err: got %0d expected 2", bus.err_count); end
        if (bus.first_err_vec !== 3'd3) begin errors++; $display("[TB] FAIL corrupt_fvec: got %0d expected 3", bus.first_err_vec); end
        if (bus.first_err_resp !== resp_tbl[3]) begin
            errors++;
            $display("[TB] FAIL corrupt_fresp: got %0d expected %0d", bus.first_err_resp, resp_tbl[3]);
        end
    endtask

    task automatic test_all_wrong();
        for (int v = 0; v < N_VEC; v++) resp_tbl[v] = ~golden(v);
        run_sweep(0);
        checks += 4;
        if (bus.err_count !== 4'b1000) begin errors++; $display("[TB] FAIL allwrong_err: got %0d expected 8", bus.err_count); end
        if (bus.first_err_vec !== 3'd0) begin errors++; $display("[TB] FAIL allwrong_fvec: got %0d expected 0", bus.first_err_vec); end
        if (bus.first_err_resp !== ~golden(0)) begin
            errors++;
            $display("[TB] FAIL allwrong_fresp: got %0d expected %0d", bus.first_err_resp, ~golden(0));
        end
        if (bus.pass !== 1'b0) begin errors++; $display("[TB] FAIL allwrong_pass: got %b expected 0", bus.pass); end
    endtask

    task automatic test_restart_after_fail();
        set_golden();
        run_sweep(0);
        checks += 3;
        if (bus.pass !== 1'b1) begin errors++; $display("[TB] FAIL restart_pass: got %b expected 1", bus.pass); end
        if (bus.err_count !== 4'd0) begin errors++; $display("[TB] FAIL restart_err: got %0d expected 0", bus.err_count); end
        if (bus.first_err_vec !== 3'd0) begin errors++; $display("[TB] FAIL restart_fvec: got %0d expected 0", bus.first_err_vec); end
    endtask

    task automatic test_start_mid_sweep();
        set_golden();
        run_sweep(6);
        checks += 2;
        if (bus.pass !== 1'b1) begin errors++; $display("[TB] FAIL midstart_pass: got %b expected 1", bus.pass); end
        if (bus.err_count !== 4'd0) begin errors++; $display("[TB] FAIL midstart_err: got %0d expected 0", bus.err_count); end
    endtask

    task automatic test_reset_mid_sweep();
        for (int v = 0; v < N_VEC; v++) resp_tbl[v] = ~golden(v);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (bus.vec_out !== 3'd0) begin errors++; $display("[TB] FAIL midrst_vec: got %0d expected 0", bus.vec_out); end
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", bus.done); end
        if (bus.pass !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pass: got %b expected 0", bus.pass); end
        if (bus.err_count !== 4'd0) begin errors++; $display("[TB] FAIL midrst_err: got %0d expected 0", bus.err_count); end
        if (bus.first_err_vec !== 3'd0) begin errors++; $display("[TB] FAIL midrst_fvec: got %0d expected 0", bus.first_err_vec); end
        if (bus.first_err_resp !== 2'd0) begin errors++; $display("[TB] FAIL midrst_fresp: got %0d expected 0", bus.first_err_resp); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle_busy: got %b expected 0", bus.busy); end
        if (bus.vec_out !== 3'd0) begin errors++; $display("[TB] FAIL midrst_idle_vec: got %0d expected 0", bus.vec_out); end
        set_golden();
        run_sweep(0);
        checks += 2;
        if (bus.pass !== 1'b1) begin errors++; $display("[TB] FAIL midrst_fresh_pass: got %b expected 1", bus.pass); end
        if (bus.err_count !== 4'd0) begin errors++; $display("[TB] FAIL midrst_fresh_err: got %0d expected 0", bus.err_count); end
    endtask

    task automatic test_random();
        int n_err, f_vec, f_resp;
        for (int it = 0; it < 10; it++) begin
            for (int v = 0; v < N_VEC; v++)
                resp_tbl[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : golden(v);
            model(n_err, f_vec, f_resp);
            glitch_en = 1'($urandom_range(0, 1));
            run_sweep(int'($urandom_range(0, SWEEP)));
            checks += 4;
            if (int'(bus.err_count) != n_err) begin
                errors++;
                $display("[TB] FAIL rand%0d_err: got %0d expected %0d", it, bus.err_count, n_err);
            end
            if (bus.pass !== (n_err == 0)) begin
                errors++;
                $display("[TB] FAIL rand%0d_pass: got %b expected %b", it, bus.pass, n_err == 0);
            end
            if (int'(bus.first_err_vec) != f_vec) begin
                errors++;
                $display("[TB] FAIL rand%0d_fvec: got %0d expected %0d", it, bus.first_err_vec, f_vec);
            end
            if (int'(bus.first_err_resp) != f_resp) begin
                errors++;
                $display("[TB] FAIL rand%0d_fresp: got %0d expected %0d", it, bus.first_err_resp, f_resp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_corrupted_entries();
        test_all_wrong();
        test_restart_after_fail();
        test_start_mid_sweep();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Synthesizable counterpart to the exhaustive combinational benches. It drives every input combination (000..111 for 3 inputs) onto a combinational DUT, holds each vector for a programmable settle time, and samples the DUT outputs. It compares each sample against an expected truth table held as a parameter, then reports pass/fail, the error count and the first failing vector. It sits beside a DUT such as the F1/F2 exercise logic, so the sweep can run on hardware without a simulator monitor.

Parameters:
N_IN, 3, number of DUT inputs; sweep length is 2**N_IN vectors.
N_OUT, 2, number of DUT outputs compared.
HOLD, 4, clock cycles each vector is held; legal range is 2 or more.
EXP_TABLE, all zeros, expected responses, N_OUT*2**N_IN bits wide.
- The slice EXP_TABLE[v*N_OUT +: N_OUT] is the expected resp_in for vector v.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous reset, active low.
start  in  1  one-cycle pulse that begins a sweep.
vec_out  out  N_IN  stimulus to the DUT; MSB is x, LSB is z in the 3-input case.
resp_in  in  N_OUT  DUT outputs; MSB is F1, LSB is F2 in the 2-output case.
busy  out  1  high while a sweep is in progress.
done  out  1  high when a sweep has completed; stays high until the next start.
pass  out  1  valid while done is high; 1 if err_count == 0.
err_count  out  N_IN+1  number of mismatching vectors; cannot overflow.
first_err_vec  out  N_IN  index of the first mismatching vector.
first_err_resp  out  N_OUT  resp_in value captured at the first mismatch.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE.
  - vec_out=0, busy=0, done=0, pass=0, err_count=0.
  - first_err_vec=0, first_err_resp=0.
  - Hold counter = 0, vector index = 0.
- FSM states are IDLE, DRIVE, LAST, DONE.
- IDLE:
  - start=1 at an edge -> DRIVE; busy=1; index=0; vec_out=0; hold counter=0.
  - err_count, first_err_* and done are cleared on the same edge.
- DRIVE:
  - vec_out = index.
  - The hold counter increments each cycle.
  - When the counter equals HOLD-1, resp_in is sampled and compared with EXP_TABLE[index] on that edge.
  - On a mismatch, err_count increments. If this is the first mismatch, first_err_vec=index and first_err_resp=resp_in are latched.
  - After the sample, the hold counter returns to 0.
  - If index < 2**N_IN-1, index increments and vec_out changes on that same edge.
  - Otherwise the FSM goes to LAST.
- LAST (exactly one cycle):
  - busy=0, done=1.
  - pass = (err_count == 0), evaluated after the final compare has been included.
  - vec_out holds the final vector.
  - Next state is DONE.
- DONE:
  - Outputs are held.
  - start=1 -> a new sweep begins exactly as from IDLE.
- Latency: with start sampled at edge 0, the first sample is at edge HOLD and the last sample at edge HOLD*2**N_IN. done rises at edge HOLD*2**N_IN+1.
- start while busy=1 is ignored and the sweep continues unchanged.
- start in the same cycle as the final sample is ignored.
- Reset asserted mid-sweep: all outputs immediately return to their reset values and the sweep is abandoned.
- Sampling discipline: each vector gets HOLD-1 full cycles of settle before it is sampled. resp_in is assumed combinational from vec_out. No other resp_in value ever affects the result.
- err_count is N_IN+1 bits wide, so it holds up to 2**N_IN without saturation logic.

Test Plan:
- HOLD=2, EXP_TABLE matches the DUT model; start pulse -> busy for 16 cycles, vec_out steps 0..7 every 2 cycles, done=1 at cycle 17, pass=1, err_count=0.
- EXP_TABLE with entries 3 and 5 corrupted -> done=1, pass=0, err_count=2, first_err_vec=3'b011, first_err_resp = DUT value at 3.
- Every expected entry wrong (EXP_TABLE inverted) -> err_count=8 (4'b1000), no wrap, first_err_vec=0.
- start pulsed again at cycle 6 mid-sweep -> ignored; vec_out sequence and done timing identical to the first scenario.
- rst_n low at cycle 9 for 1 cycle -> all outputs 0 immediately, state IDLE; a fresh start completes a normal sweep.
- A second start while done=1 after a failing sweep -> err_count and done clear on the start edge; a clean DUT ends with pass=1.
